render_queue: RTL and testbench
===============================

Name: render_queue

Overview:
- Avalon memory-mapped slave that accepts sprite render commands from software and buffers them in a FIFO.
- Presents the head command to the display stage (vga_display) as a 48-bit word: magic[47:40], x[39:24], y[23:8], flags[7:0].
- Software assembles each command in staging registers through three 16-bit writes, then commits it with a push write.
- When the FIFO is empty, the output shows a synthetic DO_RENDER word so the display stage returns to its wait-for-frame state.

Parameters:
- DEPTH, 25, number of 48-bit FIFO entries (render queue length).
- CNT_W, 5, width of the occupancy and pointer counters; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  3  Avalon word address.
- writedata  in  16  Avalon write data.
- readdata  out  16  Avalon read data; registered.
- render_queue_dout  out  48  head command, show-ahead.
- render_queue_pop_front  in  1  consumer pop request; level-sensitive.
- queue_empty  out  1  FIFO empty flag.
- queue_full  out  1  FIFO full flag.

Behaviour:
- Clock and reset: one clock, clk50. Reset is asynchronous and active-high. All registers clear on posedge reset.
- Reset values:
  - Pointers and count = 0; staging registers = 0; overflow = 0; readdata = 0.
  - queue_empty = 1, queue_full = 0.
  - render_queue_dout = 48'hFF00_0000_0000 (DO_RENDER word).
- Write map (chipselect & write, sampled on posedge clk50):
  - addr 0: stage_magic <= writedata[15:8]; stage_flags <= writedata[7:0].
  - addr 1: stage_x <= writedata.
  - addr 2: stage_y <= writedata.
  - addr 3: push {stage_magic, stage_x, stage_y, stage_flags}; writedata ignored; staging registers keep their values.
  - addr 4: flush. Pointers and count <= 0, overflow <= 0. Staging registers unaffected.
  - addr 5-7: ignored.
- Read map (chipselect & read): readdata updates on the next posedge (1-cycle latency); otherwise it holds.
  - addr 0: {8'b0, overflow, full, empty, count[4:0]}.
  - addr 1: {stage_magic, stage_flags}.
  - addr 2: stage_x.
  - addr 3: stage_y.
  - others: 16'h0000.
- Push: when not full, store the entry at wr_ptr; wr_ptr wraps DEPTH-1 -> 0; count+1.
- Push when full: entry dropped, overflow <= 1 (sticky until flush or reset), count unchanged.
- Pop: on each posedge with render_queue_pop_front=1 and not empty, rd_ptr advances (wrapping DEPTH-1 -> 0) and count-1. Pop while empty has no effect and no error.
- Simultaneous push and pop:
  - Not empty and not full: both happen, count unchanged.
  - Empty: push only; the pop is ignored and the new entry becomes visible the following cycle.
  - Full: pop frees a slot and the push is accepted in the same cycle; no overflow.
- Flush in the same cycle as a push or pop: flush wins; the push is discarded.
- render_queue_dout is combinational from head storage: mem[rd_ptr] when count>0, else the DO_RENDER word. Pushed data is visible one cycle after the push edge.
- Flags: empty = (count==0); full = (count==DEPTH). Both are combinational from the registered count.
- Storage is a register array or MLAB; no reset on the data array is required, since the output is masked while empty.
- Reset asserted mid-operation: queue emptied immediately (asynchronous); any in-flight push is lost.

Test Plan:
- Reset, then read addr 0 -> readdata=16'h0020 (empty=1); render_queue_dout=48'hFF0000000000.
- Write addr0=16'h0201, addr1=16'd320, addr2=16'd240, addr3 -> next cycle dout=48'h02_0140_00F0_01, status count=1. Hold pop high 1 cycle -> dout back to DO_RENDER, empty=1.
- Push 25 distinct entries -> full=1, count=25. 26th push -> overflow=1, count=25. Pop all 25 -> values in push order; wrap-around verified.
- With 24 entries queued, push and pop in the same cycle for 10 cycles -> count stays 24, popped order intact. At full, simultaneous push/pop -> no overflow.
- Pop held high for 5 cycles while empty -> count stays 0, no pointer drift. A later push is read back correctly.
- Queue 7 entries plus overflow set, then write addr 4 -> count=0, overflow=0, staging retained (read addr 1 returns the last staged magic/flags). Assert reset mid-push -> empty immediately.

Source files
------------

// File: rtl/render_queue.sv
// render_queue: Avalon-MM slave buffering sprite render commands for vga_display.
//
// Software builds a command in three 16-bit staging registers, then commits it
// to a DEPTH-entry FIFO with a push write. The head of the FIFO is presented
// show-ahead on render_queue_dout; while the FIFO is empty a synthetic DO_RENDER
// word is shown instead so the display stage falls back to waiting for a frame.
//
// Ports:
//   clk50, reset              clock (50 MHz) and async active-high reset
//   chipselect/write/read     Avalon slave strobes
//   address[2:0]              word address (see write/read maps below)
//   writedata[15:0]           write data
//   readdata[15:0]            registered read data, 1-cycle latency
//   render_queue_dout[47:0]   head command {magic, x, y, flags}
//   render_queue_pop_front    level-sensitive consumer pop
//   queue_empty, queue_full   occupancy flags decoded from the count
//
// Write map: 0 {magic,flags}, 1 x, 2 y, 3 push, 4 flush, 5-7 ignored.
// Read map:  0 status, 1 {magic,flags}, 2 x, 3 y, others 0.
module render_queue #(
  parameter int unsigned DEPTH = 25,
  parameter int unsigned CNT_W = 5
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic [47:0] render_queue_dout,
  input  logic        render_queue_pop_front,
  output logic        queue_empty,
  output logic        queue_full
);

  localparam int unsigned WORD_W  = 48;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned STAT_CW = 5;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
  localparam logic [WORD_W-1:0] DO_RENDER = 48'hFF00_0000_0000;

  localparam logic [2:0] ADDR_MAGIC = 3'd0;
  localparam logic [2:0] ADDR_X     = 3'd1;
  localparam logic [2:0] ADDR_Y     = 3'd2;
  localparam logic [2:0] ADDR_PUSH  = 3'd3;
  localparam logic [2:0] ADDR_FLUSH = 3'd4;

  // Staging registers
  logic [7:0]        stage_magic;
  logic [7:0]        stage_flags;
  logic [15:0]       stage_x;
  logic [15:0]       stage_y;

  // FIFO state
  logic [WORD_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  // Decoded strobes
  logic              bus_wr;
  logic              bus_rd;
  logic              push_req;
  logic              flush_req;
  logic              pop_ok;
  logic              push_ok;
  logic              push_drop;
  logic [WORD_W-1:0] stage_word;
  logic [CNT_W-1:0]  wr_ptr_inc;
  logic [CNT_W-1:0]  rd_ptr_inc;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] read_mux;

  // Flags are decoded straight from the registered count.
  assign queue_empty = (count == '0);
  assign queue_full  = (count == DEPTH_C);

  // Bus strobe decode.
  assign bus_wr    = chipselect & write;
  assign bus_rd    = chipselect & read;
  assign push_req  = bus_wr & (address == ADDR_PUSH);
  assign flush_req = bus_wr & (address == ADDR_FLUSH);

  // A pop only counts when there is something to pop. At full, a concurrent
  // pop frees the slot the push needs, so the push is still accepted.
  assign pop_ok    = render_queue_pop_front & ~queue_empty;
  assign push_ok   = push_req & (~queue_full | pop_ok);
  assign push_drop = push_req & queue_full & ~pop_ok;

  assign stage_word = {stage_magic, stage_x, stage_y, stage_flags};

  // Pointer increments wrap at DEPTH-1 rather than at the counter width.
  assign wr_ptr_inc = (wr_ptr == LAST_C) ? '0 : wr_ptr + ONE_C;
  assign rd_ptr_inc = (rd_ptr == LAST_C) ? '0 : rd_ptr + ONE_C;

  // Show-ahead head word, masked while empty so stale storage never leaks out.
  assign render_queue_dout = queue_empty ? DO_RENDER : mem[rd_ptr];

  // Status register layout.
  assign status_word = {8'b0, overflow, queue_full, queue_empty, STAT_CW'(count)};

  // Read data selection.
  always_comb begin
    read_mux = '0;
    case (address)
      3'd0:    read_mux = status_word;
      3'd1:    read_mux = {stage_magic, stage_flags};
      3'd2:    read_mux = stage_x;
      3'd3:    read_mux = stage_y;
      default: read_mux = '0;
    endcase
  end

  // Staging registers; untouched by push and flush.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      stage_magic <= '0;
      stage_flags <= '0;
      stage_x     <= '0;
      stage_y     <= '0;
    end else if (bus_wr) begin
      case (address)
        ADDR_MAGIC: begin
          stage_magic <= writedata[15:8];
          stage_flags <= writedata[7:0];
        end
        ADDR_X:  stage_x <= writedata;
        ADDR_Y:  stage_y <= writedata;
        default: ;
      endcase
    end
  end

  // Storage array; no reset needed because the output is masked while empty.
  always_ff @(posedge clk50) begin
    if (push_ok && !flush_req) begin
      mem[wr_ptr] <= stage_word;
    end
  end

  // Pointers, occupancy and sticky overflow. Flush overrides push and pop.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_req) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (push_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Registered read data; holds when no read is issued.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (bus_rd) begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_render_queue.sv
// tb_render_queue: directed self-checking bench for render_queue.
// Inputs are driven and outputs sampled on the falling edge of clk50.
module tb_render_queue;

  localparam logic [47:0] DO_RENDER = 48'hFF00_0000_0000;
  localparam int          DEPTH     = 25;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [47:0] render_queue_dout;
  logic        render_queue_pop_front;
  logic        queue_empty;
  logic        queue_full;

  int checks   = 0;
  int failures = 0;

  logic [47:0] model [$];
  logic [7:0]  st_m;
  logic [7:0]  st_f;
  logic [15:0] st_x;
  logic [15:0] st_y;
  logic [15:0] rd;

  render_queue #(.DEPTH(25), .CNT_W(5)) dut (
    .clk50                  (clk50),
    .reset                  (reset),
    .chipselect             (chipselect),
    .write                  (write),
    .read                   (read),
    .address                (address),
    .writedata              (writedata),
    .readdata               (readdata),
    .render_queue_dout      (render_queue_dout),
    .render_queue_pop_front (render_queue_pop_front),
    .queue_empty            (queue_empty),
    .queue_full             (queue_full)
  );

  always #10 clk50 = ~clk50;

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(negedge clk50);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    @(negedge clk50);
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  // Stage a full command and push it; the model only accepts it when not full.
  task automatic stage_push(input logic [7:0] m, input logic [15:0] x,
                            input logic [15:0] y, input logic [7:0] f);
    bus_write(3'd0, {m, f});
    bus_write(3'd1, x);
    bus_write(3'd2, y);
    bus_write(3'd3, 16'h0000);
    st_m = m; st_f = f; st_x = x; st_y = y;
    if (model.size() < DEPTH) model.push_back({m, x, y, f});
  endtask

  task automatic pop_cycle();
    render_queue_pop_front = 1'b1;
    @(negedge clk50);
    render_queue_pop_front = 1'b0;
    if (model.size() > 0) void'(model.pop_front());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk50);
    checks++;
    if (readdata !== 16'h0000) begin
      failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 16'h0000);
    end
    checks++;
    if (render_queue_dout !== DO_RENDER) begin
      failures++; $display("FAIL reset_dout got=%h exp=%h", render_queue_dout, DO_RENDER);
    end
    checks++;
    if (queue_empty !== 1'b1 || queue_full !== 1'b0) begin
      failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", queue_empty, queue_full);
    end
    reset = 1'b0;
    @(negedge clk50);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0020) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", rd, 16'h0020);
    end
  endtask

  task automatic test_single();
    stage_push(8'h02, 16'd320, 16'd240, 8'h01);
    checks++;
    if (render_queue_dout !== 48'h02_0140_00F0_01) begin
      failures++; $display("FAIL single_dout got=%h exp=%h", render_queue_dout, 48'h02_0140_00F0_01);
    end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0001) begin
      failures++; $display("FAIL single_status got=%h exp=%h", rd, 16'h0001);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 16'h0201) begin
      failures++; $display("FAIL single_rd_magic got=%h exp=%h", rd, 16'h0201);
    end
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 16'h0140) begin
      failures++; $display("FAIL single_rd_x got=%h exp=%h", rd, 16'h0140);
    end
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 16'h00F0) begin
      failures++; $display("FAIL single_rd_y got=%h exp=%h", rd, 16'h00F0);
    end
    bus_read(3'd5, rd);
    checks++;
    if (rd !== 16'h0000) begin
      failures++; $display("FAIL single_rd_unmapped got=%h exp=%h", rd, 16'h0000);
    end
    pop_cycle();
    checks++;
    if (render_queue_dout !== DO_RENDER || queue_empty !== 1'b1) begin
      failures++; $display("FAIL single_pop got dout=%h empty=%b exp dout=%h empty=1", render_queue_dout, queue_empty, DO_RENDER);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++)
      stage_push(8'hC0, 16'(100 + 3 * i), 16'(16'hA000 + i), 8'(i));
    checks++;
    if (queue_full !== 1'b1) begin
      failures++; $display("FAIL fill_full got=%b exp=1", queue_full);
    end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0059) begin
      failures++; $display("FAIL fill_status got=%h exp=%h", rd, 16'h0059);
    end
    stage_push(8'hEE, 16'hDEAD, 16'hBEEF, 8'h55);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h00D9) begin
      failures++; $display("FAIL fill_overflow_status got=%h exp=%h", rd, 16'h00D9);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (render_queue_dout !== model[0]) begin
        failures++; $display("FAIL fill_drain[%0d] got=%h exp=%h", i, render_queue_dout, model[0]);
      end
      pop_cycle();
    end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h00A0) begin
      failures++; $display("FAIL fill_drained_status got=%h exp=%h", rd, 16'h00A0);
    end
  endtask

  task automatic test_back_to_back();
    bus_write(3'd4, 16'h0000);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0020) begin
      failures++; $display("FAIL b2b_flush_status got=%h exp=%h", rd, 16'h0020);
    end
    for (int i = 0; i < DEPTH - 1; i++)
      stage_push(8'h50, 16'(200 + i), 16'(7 * i), 8'(i));
    for (int k = 0; k < 10; k++) begin
      bus_write(3'd1, 16'(1000 + k));
      st_x = 16'(1000 + k);
      checks++;
      if (render_queue_dout !== model[0]) begin
        failures++; $display("FAIL b2b_head[%0d] got=%h exp=%h", k, render_queue_dout, model[0]);
      end
      render_queue_pop_front = 1'b1;
      bus_write(3'd3, 16'h0000);
      render_queue_pop_front = 1'b0;
      void'(model.pop_front());
      model.push_back({st_m, st_x, st_y, st_f});
    end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0018) begin
      failures++; $display("FAIL b2b_count24 got=%h exp=%h", rd, 16'h0018);
    end
    stage_push(8'h51, 16'h2222, 16'h3333, 8'h44);
    bus_write(3'd1, 16'h7777);
    st_x = 16'h7777;
    render_queue_pop_front = 1'b1;
    bus_write(3'd3, 16'h0000);
    render_queue_pop_front = 1'b0;
    void'(model.pop_front());
    model.push_back({st_m, st_x, st_y, st_f});
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0059) begin
      failures++; $display("FAIL b2b_full_pushpop got=%h exp=%h", rd, 16'h0059);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (render_queue_dout !== model[0]) begin
        failures++; $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, render_queue_dout, model[0]);
      end
      pop_cycle();
    end
  endtask

  task automatic test_pop_empty();
    render_queue_pop_front = 1'b1;
    repeat (5) @(negedge clk50);
    render_queue_pop_front = 1'b0;
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0020) begin
      failures++; $display("FAIL pop_empty_status got=%h exp=%h", rd, 16'h0020);
    end
    stage_push(8'h33, 16'h1234, 16'h5678, 8'h9A);
    checks++;
    if (render_queue_dout !== 48'h33_1234_5678_9A) begin
      failures++; $display("FAIL pop_empty_push got=%h exp=%h", render_queue_dout, 48'h33_1234_5678_9A);
    end
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0001) begin
      failures++; $display("FAIL pop_empty_count got=%h exp=%h", rd, 16'h0001);
    end
    pop_cycle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++)
      stage_push(8'h70, 16'(i), 16'(50 + i), 8'h0F);
    stage_push(8'h71, 16'h0001, 16'h0002, 8'h03);
    render_queue_pop_front = 1'b1;
    repeat (18) @(negedge clk50);
    render_queue_pop_front = 1'b0;
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0087) begin
      failures++; $display("FAIL flush_pre_status got=%h exp=%h", rd, 16'h0087);
    end
    bus_write(3'd0, 16'h5A3C);
    bus_write(3'd4, 16'h0000);
    model.delete();
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0020) begin
      failures++; $display("FAIL flush_status got=%h exp=%h", rd, 16'h0020);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 16'h5A3C) begin
      failures++; $display("FAIL flush_staging got=%h exp=%h", rd, 16'h5A3C);
    end
    checks++;
    if (render_queue_dout !== DO_RENDER) begin
      failures++; $display("FAIL flush_dout got=%h exp=%h", render_queue_dout, DO_RENDER);
    end
  endtask

  task automatic test_reset_mid();
    stage_push(8'h11, 16'h0101, 16'h0202, 8'h03);
    stage_push(8'h12, 16'h0404, 16'h0505, 8'h06);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 3'd3;
    #3 reset = 1'b1;
    #1;
    checks++;
    if (queue_empty !== 1'b1 || render_queue_dout !== DO_RENDER) begin
      failures++; $display("FAIL midreset_async got empty=%b dout=%h exp empty=1 dout=%h", queue_empty, render_queue_dout, DO_RENDER);
    end
    checks++;
    if (readdata !== 16'h0000) begin
      failures++; $display("FAIL midreset_readdata got=%h exp=%h", readdata, 16'h0000);
    end
    @(negedge clk50);
    chipselect = 1'b0;
    write      = 1'b0;
    reset      = 1'b0;
    model.delete();
    @(negedge clk50);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== 16'h0020) begin
      failures++; $display("FAIL midreset_status got=%h exp=%h", rd, 16'h0020);
    end
  endtask

  initial begin
    reset                  = 1'b1;
    chipselect             = 1'b0;
    write                  = 1'b0;
    read                   = 1'b0;
    address                = 3'd0;
    writedata              = 16'h0000;
    render_queue_pop_front = 1'b0;
    st_m = '0; st_f = '0; st_x = '0; st_y = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_pop_empty();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
